// File: rtl/xilinx_sp_distram_ctrl.sv
// Single-port distributed RAM with byte-lane writes and a self-clearing sweep.
// Define XILINX_DISTRAM_OREG_EN for a registered, read-first output stage.
module xilinx_sp_distram_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8,
    parameter int BYTE_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                             WCLK,
    input  logic                             RST,
    input  logic [ADDR_WIDTH-1:0]            A,
    input  logic [DATA_WIDTH-1:0]            D,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] WE,
    input  logic                             EN,
    input  logic                             CLR,
    output logic [DATA_WIDTH-1:0]            O,
    output logic                             O_VALID,
    output logic                             BUSY,
    output logic                             DONE
);

    localparam int RAM_DEPTH = 2 ** ADDR_WIDTH;
    localparam int NUM_LANES = DATA_WIDTH / BYTE_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_WIDTH-1:0]   r_ptr;
    logic                    r_done;
    logic                    w_busy;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [DATA_WIDTH-1:0]   w_rdata;
    logic [NUM_LANES-1:0]    w_lane_we;

    always_ff @(posedge WCLK or posedge RST) begin
        if (RST) begin
            r_state <= S_CLEAR;
            r_ptr   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ptr   <= (r_state == S_CLEAR) ? r_ptr + 1'b1 : '0;
            r_done  <= (r_state == S_CLEAR) && (r_ptr == LAST_ADDR);
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_CLEAR: if (r_ptr == LAST_ADDR) w_next = S_IDLE;
            S_IDLE:  if (CLR) w_next = S_CLEAR;
        endcase
    end

    // A clear request in IDLE wins over a user write on the same edge.
    always_comb begin
        w_busy    = (r_state == S_CLEAR);
        w_addr    = w_busy ? r_ptr : A;
        w_wdata   = w_busy ? CLEAR_VALUE : D;
        w_lane_we = '0;
        unique case (r_state)
            S_CLEAR: w_lane_we = '1;
            S_IDLE:  if (!CLR) w_lane_we = WE;
        endcase
    end

    for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_bit
        logic [RAM_DEPTH-1:0] r_cell;
        always_ff @(posedge WCLK) begin
            if (w_lane_we[b/BYTE_WIDTH])
                r_cell[w_addr] <= w_wdata[b];
        end
        assign w_rdata[b] = r_cell[w_addr];
    end

`ifdef XILINX_DISTRAM_OREG_EN
    logic [DATA_WIDTH-1:0] r_o;
    logic                  r_valid;

    always_ff @(posedge WCLK or posedge RST) begin
        if (RST) begin
            r_o     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= EN && !w_busy;
            if (EN && !w_busy)
                r_o <= w_rdata;
        end
    end

    assign O       = r_o;
    assign O_VALID = r_valid;
`else
    assign O       = w_rdata;
    assign O_VALID = EN && !w_busy;
`endif

    assign BUSY = w_busy;
    assign DONE = r_done;

endmodule
